// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-ID handshake bundle for the dual-issue instruction queue.
// Pure wiring; no latency of its own.
// Backpressure travels as in_ready (fetch side) and pop_a/pop_b (ID side).
interface inst_fetch_queue_if;
    // fetch side
    logic        flush;
    logic        in_valid;
    logic        in_num;
    logic [31:0] in_pc;
    logic [31:0] in_inst0;
    logic [31:0] in_inst1;
    logic        in_excp;
    logic        in_ready;

    // ID side
    logic        out_valid_a;
    logic        out_valid_b;
    logic [31:0] out_pc_a;
    logic [31:0] out_pc_b;
    logic [31:0] out_inst_a;
    logic [31:0] out_inst_b;
    logic        out_excp_a;
    logic        out_excp_b;
    logic        pop_a;
    logic        pop_b;

    // driver of the queue (fetch + ID stages together)
    modport master (
        output flush, in_valid, in_num, in_pc, in_inst0, in_inst1, in_excp,
        output pop_a, pop_b,
        input  in_ready,
        input  out_valid_a, out_valid_b, out_pc_a, out_pc_b,
        input  out_inst_a, out_inst_b, out_excp_a, out_excp_b
    );

    // the queue itself
    modport slave (
        input  flush, in_valid, in_num, in_pc, in_inst0, in_inst1, in_excp,
        input  pop_a, pop_b,
        output in_ready,
        output out_valid_a, out_valid_b, out_pc_a, out_pc_b,
        output out_inst_a, out_inst_b, out_excp_a, out_excp_b
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction queue: absorbs 1-2 fetched instructions/cycle, exposes the two oldest.
// Latency: push visible at slot A/B one cycle later; slot read is first-word fall-through.
// Backpressure: in_ready drops when fewer than two free entries remain (registered count only).
module inst_fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
    } entry_t;

    entry_t mem [DEPTH];

    ptr_t   head;
    ptr_t   tail;
    cnt_t   count;

    ptr_t   head_next;
    ptr_t   tail_next;
    cnt_t   count_next;
    ptr_t   head_p1;
    ptr_t   tail_p1;

    logic       ready;
    logic       push;
    logic       push_two;
    logic [1:0] n_push;
    logic       valid_a;
    logic       valid_b;
    logic       ea;
    logic       eb;
    entry_t     ent_a;
    entry_t     ent_b;

    // Push side: room for a full pair is required even for a single, so fetch never has to split.
    always_comb begin
        ready    = (count <= cnt_t'(DEPTH - 2));
        push     = q.in_valid & ready & ~q.flush & ~rst;
        push_two = push & q.in_num;
        n_push   = push ? (q.in_num ? 2'd2 : 2'd1) : 2'd0;
        tail_p1  = tail + ptr_t'(1);
        tail_next = tail + ptr_t'(n_push);
    end

    // Pop side: slot B can only retire together with slot A, and never from an empty slot.
    always_comb begin
        valid_a   = (count != cnt_t'(0));
        valid_b   = (count >= cnt_t'(2));
        ea        = q.pop_a & valid_a;
        eb        = q.pop_b & ea & valid_b;
        head_p1   = head + ptr_t'(1);
        head_next = head + ptr_t'(ea) + ptr_t'(eb);
        count_next = count + cnt_t'(n_push) - cnt_t'(ea) - cnt_t'(eb);
    end

    // Pointer/occupancy state; rst and flush both empty the queue, array contents are left stale.
    always_ff @(posedge clk) begin
        if (rst || q.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
        end
    end

    // Entry storage: inst0 lands at tail, inst1 (pc+4) at tail+1; excp tags every entry of the burst.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{pc: q.in_pc, inst: q.in_inst0, excp: q.in_excp};
        end
        if (push_two) begin
            mem[tail_p1] <= '{pc: q.in_pc + 32'd4, inst: q.in_inst1, excp: q.in_excp};
        end
    end

    // Fall-through read of the two oldest entries, zeroed when the slot is empty.
    always_comb begin
        ent_a = valid_a ? mem[head]    : '0;
        ent_b = valid_b ? mem[head_p1] : '0;

        q.in_ready    = ready;
        q.out_valid_a = valid_a;
        q.out_valid_b = valid_b;
        q.out_pc_a    = ent_a.pc;
        q.out_inst_a  = ent_a.inst;
        q.out_excp_a  = ent_a.excp;
        q.out_pc_b    = ent_b.pc;
        q.out_inst_b  = ent_b.inst;
        q.out_excp_b  = ent_b.excp;
    end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Dual-issue instruction queue between the fetch stage and the ID stage. It absorbs fetch bursts of one or two instructions per cycle and presents the two oldest instructions as issue slots A and B. The ID stage pops one instruction per cycle, or two when superscalar control grants the second slot. A pipeline flush (branch redirect or exception) empties the queue.

## Interface
- DEPTH, 8: number of instruction entries; power of two, ≥ 4.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all entries this cycle.
- in_valid  in  1  fetch presents data.
- in_num  in  1  0: one instruction (inst0 only); 1: two instructions.
- in_pc  in  32  PC of inst0; inst1 PC is in_pc+4.
- in_inst0, in_inst1  in  32 each  instruction words.
- in_excp  in  1  fetch exception flag; attached to every entry pushed this cycle.
- in_ready  out  1  queue accepts a push this cycle.
- out_valid_a, out_valid_b  out  1 each  slot A (oldest) / slot B (second oldest) holds an entry.
- out_pc_a, out_pc_b  out  32 each  PCs of slots A/B.
- out_inst_a, out_inst_b  out  32 each  instruction words of slots A/B.
- out_excp_a, out_excp_b  out  1 each  exception flags of slots A/B.
- pop_a  in  1  ID consumes slot A.
- pop_b  in  1  ID consumes slot B (second instruction taken).

## Operation
- Storage: DEPTH entries of {pc[31:0], inst[31:0], excp}. Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- in_ready = (DEPTH − count ≥ 2). It uses the registered count only; same-cycle pops do not raise it.
- push = in_valid & in_ready & ~flush. Number pushed n_push = push ? (in_num ? 2 : 1) : 0.
- inst0 is written at tail and inst1 at tail+1 (mod DEPTH). tail advances by n_push.
- out_valid_a = (count ≥ 1). out_valid_b = (count ≥ 2).
- Slot A is entry[head]; slot B is entry[head+1 mod DEPTH]. The read is combinational (first-word fall-through).
- Data and excp outputs are forced to 0 when the corresponding valid is low.
- Effective pops:
  - ea = pop_a & out_valid_a.
  - eb = pop_b & ea & out_valid_b.
  - A pop_b without pop_a, or a pop on an invalid slot, is ignored.
- head advances by ea+eb. count_next = count + n_push − ea − eb.
- Simultaneous push and pop in the same cycle are both honoured. A pushed entry is never visible at the outputs in its push cycle.
- flush: head, tail and count are set to 0 next cycle. It overrides push and pop in the same cycle. The entry array is not cleared.
- rst: same effect as flush, and takes priority over it.

## Timing
- Reset values: count=0, head=tail=0. Hence in_ready=1, out_valid_a=out_valid_b=0, and all data outputs 0.
- Push-to-output latency is 1 cycle: a push at edge N is visible at slot A/B after edge N, if it is the oldest.
- Pop effect is seen after the same edge: slots shift by ea+eb.
- Full boundary: count = DEPTH−1 gives in_ready=0, even if in_num=0 would fit.
- Empty boundary: count=0 gives both valids 0, and pops are ignored.
- count=1: only slot A is valid, and pop_b is ignored.
- Flush and in_valid asserted together in the cycle after flush: the queue is empty after that cycle's edge and accepts the new push, which is visible 1 cycle later.

## Test plan
1. Reset, then idle. Required: in_ready=1, both valids 0, all data outputs 0.
2. Push in_pc=0xBFC00000, in_num=1, inst 0x11111111 / 0x22222222. Next cycle: slot A = (0xBFC00000, 0x11111111) and slot B = (0xBFC00004, 0x22222222). Pop_a+pop_b: both valids go to 0.
3. Push 2; pop_a only, pop_b=0. Slot A becomes the former B (pc 0xBFC00004) and out_valid_b=0. Then assert pop_b alone: the pop is ignored and the state is unchanged.
4. Fill with pairs, DEPTH=8, no pops. After 3 pairs count=6 and in_ready=1. Push one more single: count=7 and in_ready=0. Then pop 1: count=6 and in_ready=1.
5. Wrap-around: 20 cycles of push pair plus pop pair with sequential PCs. Slot A PCs must increment by 8 each cycle with no loss or duplication across the pointer wrap.
6. With count=5, assert flush, push and pop_a in the same cycle. Next cycle: count=0 and valids 0. Push in the following cycle: it appears with correct pc and excp. Also: assert rst mid-stream and check the empty state next cycle.
